// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, control bundle encodings and branch FSM states
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // wb = {RegWrite, WBsel}, me = {Branch, MemRead, MemWrite}, ex = {RegDst, ALUOp1, ALUOp0, ALUSrc}
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] me;
    logic [3:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP   = 9'b00_000_0000;
  localparam ctrl_t CTRL_RTYPE = 9'b11_000_0100;
  localparam ctrl_t CTRL_LW    = 9'b10_010_1001;
  localparam ctrl_t CTRL_SW    = 9'b00_001_1001;
  localparam ctrl_t CTRL_BEQ   = 9'b00_100_0010;
  localparam ctrl_t CTRL_ADDI  = 9'b11_000_1001;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BR_EX  = 2'd1,
    BR_MEM = 2'd2
  } br_state_t;

endpackage

// File: rtl/main_control.sv
// rtl/main_control.sv - combinational opcode to control bundle decoder
module main_control
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl,
  output logic       illegal_op
);

  always_comb begin
    ctrl       = CTRL_NOP;
    illegal_op = 1'b0;
    case (op)
      OP_RTYPE: ctrl = CTRL_RTYPE;
      OP_LW:    ctrl = CTRL_LW;
      OP_SW:    ctrl = CTRL_SW;
      OP_BEQ:   ctrl = CTRL_BEQ;
      OP_ADDI:  ctrl = CTRL_ADDI;
      default:  illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC, IF/ID register, decode, load-use and branch bubbles
module fetch_decode_unit
  import mips_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_adx,
  input  logic [31:0]       imem_data,
  input  logic              Branch,
  output logic [31:0]       instr,
  output logic [1:0]        WBID,
  output logic [2:0]        MEID,
  output logic [3:0]        EXID,
  output logic              stall,
  output logic              illegal
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] brtgt_q, brtgt_d;
  logic        ex_memread_q, ex_memread_d;
  logic [4:0]  ex_rt_q, ex_rt_d;
  logic        illegal_q, illegal_d;
  br_state_t   state_q, state_d;

  logic [5:0]  id_op;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  ctrl_t       dec_ctrl;
  ctrl_t       id_ctrl;
  logic        dec_illegal;
  logic        uses_rt;
  logic        load_use;
  logic        id_issue;

  assign id_op = instr_q[31:26];
  assign id_rs = instr_q[25:21];
  assign id_rt = instr_q[20:16];

  main_control u_main_control (
    .op         (id_op),
    .ctrl       (dec_ctrl),
    .illegal_op (dec_illegal)
  );

  always_comb begin
    uses_rt  = (id_op == OP_RTYPE) || (id_op == OP_BEQ) || (id_op == OP_SW);
    load_use = id_valid_q && ex_memread_q && (ex_rt_q != 5'd0) &&
               ((ex_rt_q == id_rs) || (uses_rt && (ex_rt_q == id_rt)));
    id_issue = id_valid_q && !load_use;
    id_ctrl  = id_issue ? dec_ctrl : CTRL_NOP;
  end

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    brtgt_d      = brtgt_q;
    state_d      = state_q;
    ex_memread_d = id_ctrl.me[1];
    ex_rt_d      = id_issue ? id_rt : 5'd0;
    illegal_d    = illegal_q | (id_issue & dec_illegal);

    case (state_q)
      RUN: begin
        // A load-use hazard freezes PC and IF/ID; it also wins over a beq issue.
        if (!load_use) begin
          if (id_issue && (id_op == OP_BEQ)) begin
            brtgt_d    = id_pc_q + 32'd4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
            instr_d    = 32'd0;
            id_pc_d    = 32'd0;
            id_valid_d = 1'b0;
            state_d    = BR_EX;
          end else begin
            instr_d    = imem_data;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end
        end
      end
      BR_EX: begin
        instr_d    = 32'd0;
        id_pc_d    = 32'd0;
        id_valid_d = 1'b0;
        state_d    = BR_MEM;
      end
      BR_MEM: begin
        instr_d    = 32'd0;
        id_pc_d    = 32'd0;
        id_valid_d = 1'b0;
        if (Branch) begin
          pc_d = brtgt_q;
        end
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      id_pc_q      <= 32'd0;
      id_valid_q   <= 1'b0;
      brtgt_q      <= 32'd0;
      ex_memread_q <= 1'b0;
      ex_rt_q      <= 5'd0;
      illegal_q    <= 1'b0;
      state_q      <= RUN;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
      brtgt_q      <= brtgt_d;
      ex_memread_q <= ex_memread_d;
      ex_rt_q      <= ex_rt_d;
      illegal_q    <= illegal_d;
      state_q      <= state_d;
    end
  end

  assign imem_adx = pc_q[ADDR_W+1:2];
  assign instr    = instr_q;
  assign WBID     = id_ctrl.wb;
  assign MEID     = id_ctrl.me;
  assign EXID     = id_ctrl.ex;
  assign stall    = !id_issue;
  assign illegal  = illegal_q | (id_issue & dec_illegal);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  localparam logic [31:0] RPC = 32'h40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  imem_adx;
  logic [31:0] imem_data;
  logic        Branch = 1'b0;
  logic [31:0] instr;
  logic [1:0]  WBID;
  logic [2:0]  MEID;
  logic [3:0]  EXID;
  logic        stall;
  logic        illegal;

  logic [31:0] imem [0:1023];
  int errors = 0;
  int checks = 0;

  assign imem_data = imem[imem_adx];

  always #5 clk = ~clk;

  fetch_decode_unit #(.ADDR_W(10), .RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_adx  (imem_adx),
    .imem_data (imem_data),
    .Branch    (Branch),
    .instr     (instr),
    .WBID      (WBID),
    .MEID      (MEID),
    .EXID      (EXID),
    .stall     (stall),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] word;
    logic [8:0]  ctrl;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        stall;
    logic [8:0]  ctrl;
    logic        ill;
    logic        br;
  } slot_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    Branch = 1'b0;
    @(negedge clk);
    check("reset_adx", {22'd0, imem_adx}, 32'h10);
    check("reset_instr", instr, 32'd0);
    check("reset_ctrl", {23'd0, WBID, MEID, EXID}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd1);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00: return 9'b11_000_0100;
      6'h23: return 9'b10_010_1001;
      6'h2B: return 9'b00_001_1001;
      6'h04: return 9'b00_100_0010;
      6'h08: return 9'b11_000_1001;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h08);
  endfunction

  // Builds the expected stream of ID slots by walking the program instruction by instruction.
  task automatic build_ref(input int n, output slot_t q[$]);
    logic [31:0] pc;
    logic [31:0] w;
    logic [31:0] nxt;
    logic [31:0] this_pc;
    logic        seen_ill;
    logic        taken;
    logic [5:0]  op;
    logic [5:0]  nop;
    logic [4:0]  lrt;
    slot_t s;
    q = {};
    pc = RPC;
    seen_ill = 1'b0;
    while (q.size() < n) begin
      w = imem[pc[11:2]];
      op = w[31:26];
      this_pc = pc;
      pc = pc + 32'd4;
      if (!legal(op)) seen_ill = 1'b1;
      s = '{instr: w, stall: 1'b0, ctrl: ref_ctrl(op), ill: seen_ill, br: 1'b0};
      q.push_back(s);
      if (op == 6'h04) begin
        taken = 1'($urandom_range(0, 1));
        for (int k = 0; k < 3; k++) begin
          s = '{instr: 32'd0, stall: 1'b1, ctrl: 9'd0, ill: seen_ill, br: (k == 1) ? taken : 1'b0};
          q.push_back(s);
        end
        if (taken) pc = this_pc + 32'd4 + {{14{w[15]}}, w[15:0], 2'b00};
      end else if (op == 6'h23 && w[20:16] != 5'd0) begin
        lrt = w[20:16];
        nxt = imem[pc[11:2]];
        nop = nxt[31:26];
        if (nxt[25:21] == lrt ||
            ((nop == 6'h00 || nop == 6'h04 || nop == 6'h2B) && nxt[20:16] == lrt)) begin
          s = '{instr: nxt, stall: 1'b1, ctrl: 9'd0, ill: seen_ill, br: 1'b0};
          q.push_back(s);
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    int          sel;
    int          off;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    sel = $urandom_range(0, 60);
    off = $urandom_range(0, 12) - 6;
    if (sel < 12) return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    else if (sel < 26) return {6'h23, rs, rt, 16'($urandom)};
    else if (sel < 34) return {6'h2B, rs, rt, 16'($urandom)};
    else if (sel < 42) return {6'h04, rs, rt, 16'(off)};
    else if (sel < 59) return {6'h08, rs, rt, 16'($urandom)};
    else return {6'h3F, rs, rt, 16'($urandom)};
  endfunction

  task automatic run_branch(input logic taken);
    clear_mem();
    imem[32'h40 >> 2]  = 32'h1000002F;
    imem[32'h100 >> 2] = 32'h10000003;
    imem[32'h104 >> 2] = 32'h20080104;
    imem[32'h110 >> 2] = 32'h20080110;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      step();
      Branch = 1'b0;
      if (c == 5) check("br_beq_in_id", instr, 32'h10000003);
      if (c >= 6 && c <= 8) begin
        check("br_bubble_stall", {31'd0, stall}, 32'd1);
        check("br_bubble_ctrl", {23'd0, WBID, MEID, EXID}, 32'd0);
      end
      if (c == 3) Branch = 1'b1;
      if (c == 7) Branch = taken;
      if (c == 9) begin
        check("br_target", instr, taken ? 32'h20080110 : 32'h20080104);
        check("br_target_stall", {31'd0, stall}, 32'd0);
      end
    end
    Branch = 1'b0;
  endtask

  vec_t  vecs[6];
  slot_t ref_q[$];

  initial begin
    vecs[0] = '{word: 32'h20080005, ctrl: 9'b11_000_1001, ill: 1'b0};
    vecs[1] = '{word: 32'h8D280000, ctrl: 9'b10_010_1001, ill: 1'b0};
    vecs[2] = '{word: 32'hAD280004, ctrl: 9'b00_001_1001, ill: 1'b0};
    vecs[3] = '{word: 32'h010B5020, ctrl: 9'b11_000_0100, ill: 1'b0};
    vecs[4] = '{word: 32'h11090003, ctrl: 9'b00_100_0010, ill: 1'b0};
    vecs[5] = '{word: 32'hFC000000, ctrl: 9'd0,           ill: 1'b1};

    for (int i = 0; i < 6; i++) begin
      clear_mem();
      imem[16] = vecs[i].word;
      do_reset();
      step();
      check("dec_instr", instr, vecs[i].word);
      check("dec_ctrl", {23'd0, WBID, MEID, EXID}, {23'd0, vecs[i].ctrl});
      check("dec_stall", {31'd0, stall}, 32'd0);
      check("dec_illegal", {31'd0, illegal}, {31'd0, vecs[i].ill});
    end

    // load-use: lw $8,0($9) then add $10,$8,$11
    clear_mem();
    imem[16] = 32'h8D280000;
    imem[17] = 32'h010B5020;
    do_reset();
    step();
    check("lu_lw_me", {29'd0, MEID}, 32'b010);
    step();
    check("lu_bubble_instr", instr, 32'h010B5020);
    check("lu_bubble_stall", {31'd0, stall}, 32'd1);
    check("lu_bubble_ctrl", {23'd0, WBID, MEID, EXID}, 32'd0);
    check("lu_bubble_adx", {22'd0, imem_adx}, 32'h12);
    step();
    check("lu_add_stall", {31'd0, stall}, 32'd0);
    check("lu_add_ctrl", {23'd0, WBID, MEID, EXID}, {23'd0, 9'b11_000_0100});
    check("lu_add_adx", {22'd0, imem_adx}, 32'h12);

    run_branch(1'b1);
    run_branch(1'b0);

    // illegal is sticky across later legal decodes and cleared by reset
    clear_mem();
    imem[16] = 32'hFC000000;
    imem[17] = 32'h20080005;
    do_reset();
    step();
    check("ill_set", {31'd0, illegal}, 32'd1);
    check("ill_ctrl", {23'd0, WBID, MEID, EXID}, 32'd0);
    step();
    check("ill_sticky", {31'd0, illegal}, 32'd1);
    check("ill_next_ctrl", {23'd0, WBID, MEID, EXID}, {23'd0, 9'b11_000_1001});
    rst_n = 1'b0;
    #1;
    check("ill_async_clear", {31'd0, illegal}, 32'd0);

    // reset while in BR_EX
    clear_mem();
    imem[16] = 32'h10000003;
    do_reset();
    step();
    check("rw_beq", instr, 32'h10000003);
    step();
    rst_n = 1'b0;
    #1;
    check("rw_adx", {22'd0, imem_adx}, 32'h10);
    check("rw_instr", instr, 32'd0);
    check("rw_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rw_refetch", instr, 32'h10000003);
    for (int c = 0; c < 4; c++) step();
    check("rw_fallthrough", instr, 32'd0);
    check("rw_adx_after", {22'd0, imem_adx}, 32'h12);

    // randomized programs against the reference stream
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1024; i++) imem[i] = rand_word();
      do_reset();
      build_ref(400, ref_q);
      for (int i = 0; i < ref_q.size(); i++) begin
        step();
        Branch = 1'b0;
        check("rnd_instr", instr, ref_q[i].instr);
        check("rnd_stall", {31'd0, stall}, {31'd0, ref_q[i].stall});
        check("rnd_ctrl", {23'd0, WBID, MEID, EXID}, {23'd0, ref_q[i].ctrl});
        check("rnd_illegal", {31'd0, illegal}, {31'd0, ref_q[i].ill});
        Branch = ref_q[i].br;
      end
      Branch = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction front end that produces the per-instruction stream consumed by the pipelined datapath: `instr` plus the ID-stage control bundles `WBID`, `MEID` and `EXID`. It holds the PC, fetches from an external combinational instruction memory, and keeps the IF/ID pipeline register. It decodes the main-control bundles and inserts bubbles for load-use hazards and unresolved branches. It consumes the datapath's `Branch` result to redirect fetch.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width.
- `RESET_PC`, 32'h0: PC value loaded at reset; must be word aligned.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_adx`  out  ADDR_W  word address, equal to `PC[ADDR_W+1:2]`.
- `imem_data`  in  32  instruction word at `imem_adx`, valid in the same cycle.
- `Branch`  in  1  taken-branch result from the datapath MEM stage.
- `instr`  out  32  IF/ID instruction word.
- `WBID`  out  2  {RegWrite, WBsel}; WBsel=1 selects the ALU result, 0 selects memory.
- `MEID`  out  3  {Branch, MemRead, MemWrite}.
- `EXID`  out  4  {RegDst, ALUOp1, ALUOp0, ALUSrc}; RegDst=1 selects Rt, 0 selects Rd.
- `stall`  out  1  the current ID slot is a bubble, caused by load-use or branch wait.
- `illegal`  out  1  sticky; set on decode of an unsupported opcode.

## Operation
- **Decode**, valid ID slot, no stall:
  - R-type, op 0x00: WB=11, ME=000, EX=0100.
  - lw, op 0x23: WB=10, ME=010, EX=1001.
  - sw, op 0x2B: WB=00, ME=001, EX=1001.
  - beq, op 0x04: WB=00, ME=100, EX=0010.
  - addi, op 0x08: WB=11, ME=000, EX=1001.
  - Any other opcode: all bundles zero, and `illegal` is set until reset.
- **Bubble**: `WBID`, `MEID` and `EXID` are all zero. `instr` continues to show the IF/ID contents.
- **Load-use shadow**: registers `ex_memread` and `ex_rt` capture `MEID[1]` and `instr[20:16]` each edge; both are zero when the ID slot is a bubble.
- **Load-use hazard**:
  - Condition: `ex_memread`=1 and `ex_rt`≠0, and `ex_rt` equals the ID rs field. For R-type, beq and sw, a match on the ID rt field also counts.
  - Response: PC and IF/ID hold, and the ID output is a bubble for exactly one cycle.
- **Branch FSM states**: RUN, BR_EX, BR_MEM.
  - RUN: a valid beq in ID with no load-use hazard is issued normally. Then `brtgt` <= id_pc+4 + (sext(imm16)<<2), using 32-bit wrap. IF/ID <= bubble, PC holds, and the state moves to BR_EX.
  - BR_EX: IF/ID <= bubble, PC holds, and the state moves to BR_MEM.
  - BR_MEM: `Branch` is sampled. PC <= `Branch` ? `brtgt` : PC. IF/ID <= bubble, and the state returns to RUN.
- **`Branch` outside BR_MEM** is ignored. Its assertion there is a bench assertion failure.
- **Normal advance in RUN**: IF/ID <= {imem_data, PC, valid=1} and PC <= PC+4, with wrap at 2^32.
- **Simultaneous events**: a load-use hazard has priority over beq issue. A beq waiting on a load is issued on the following cycle.

## Timing
- **Reset values**:
  - PC = `RESET_PC`; IF/ID = {0, 0, valid=0}; state = RUN.
  - `ex_memread` = 0 and `ex_rt` = 0.
  - Outputs: `instr` = 0, all bundles zero, `stall` = 1 (the slot is invalid), `illegal` = 0.
- **Reset mid-operation**: an assertion aborts any branch wait or stall immediately and asynchronously.
- **Latency**: fetch to ID is one cycle. The first valid instruction appears in the first cycle after reset release.
- **Branch penalty**: fixed at 3 bubble cycles, taken or not. The target or fall-through instruction is in ID on the 4th cycle after beq was in ID.
- **Load-use penalty**: 1 bubble cycle.
- **Outputs**: `WBID`, `MEID`, `EXID` and `stall` are combinational from IF/ID plus state; `instr` is registered.

## Structure
- **Package `mips_ctrl_pkg`**: holds the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI), the bundle encodings listed above including NOP, and the `br_state_t` enum {RUN, BR_EX, BR_MEM}.
- **Sub-module `main_control`**: combinational opcode-to-bundle decoder with an `illegal_op` output. The top level keeps the PC, IF/ID, shadow registers, FSM and hazard logic.

## Test plan
- **Reset**: release reset with `RESET_PC`=0x40 and imem word 0x10 = addi 0x20080005 -> `imem_adx`=0x10. Next cycle `instr`=0x20080005, WB=11, EX=1001, `stall`=0.
- **Load-use stall**: lw $8,0($9) followed by add $10,$8,$11 -> exactly one bubble cycle. add is then presented with WB=11, EX=0100, and PC held for one cycle.
- **Taken branch**: beq at 0x100 with imm=0x0003 and `Branch`=1 in BR_MEM -> 3 bubbles, then the ID slot holds the instruction from 0x110.
- **Not-taken branch**: same beq with `Branch`=0 -> 3 bubbles, then the instruction from 0x104.
- **Illegal opcode**: opcode 0x3F -> bundles zero and `illegal`=1, which persists until `rst_n` goes low.
- **Reset mid-wait**: assert `rst_n`=0 while in BR_EX -> state RUN, PC=`RESET_PC`, and the pending branch is discarded.
